matmul_sequencer: RTL and testbench
===================================

// Module: matmul_sequencer
// PURPOSE
//  Sequencer for the 3x3 MAC-array matrix multiplier. Takes K operand beats (one W column + one X row each) over valid/ready.
//  Clears the nine MACs, broadcasts operands with one load strobe per beat, then walks the unload index across all nine results.
//  Sits between the operand source and the multiplier; one job per start pulse, start/busy/done handshake.
// PARAMETERS
//  W_BITS   4  operand element width (matches data_w*/data_x* of the MAC array)
//  K_STEPS  3  inner dimension = number of operand beats per job (1..15)
//  MAC_LAT  1  cycles from a load strobe until that product is visible in res (0..7)
// PORTS
//  clk        in   1         rising-edge clock
//  rst        in   1         asynchronous, active-high reset
//  start      in   1         job request; sampled only in IDLE
//  busy       out  1         high from cycle after start accept through last UNLOAD cycle
//  done       out  1         one-cycle pulse after last unload cycle
//  in_w       in   3*W_BITS  {W[2][k],W[1][k],W[0][k]}, element i at [i*W_BITS +: W_BITS]
//  in_x       in   3*W_BITS  {X[k][2],X[k][1],X[k][0]}
//  in_valid   in   1         operand beat valid
//  in_ready   out  1         high only in FEED while beats remain
//  data_w1..3 out  W_BITS    registered row operands to MAC array
//  data_x1..3 out  W_BITS    registered column operands to MAC array
//  load       out  9         per-MAC load; bit 3*i+j drives MAC(i+1,j+1)
//  clear      out  9         per-MAC clear; same bit mapping
//  unload_res out  1         high during UNLOAD
//  res_idx    out  4         result index 0..8 (row-major) during UNLOAD, else 0
//  res_valid  out  1         qualifies res_idx / multiplier data_out
// BEHAVIOUR
//  - Reset (any time, incl. mid-job): state=IDLE, beat and index counters=0, all outputs 0; any partial job is discarded.
//  - All outputs registered. Cycle 0 = cycle in which start=1 is sampled in IDLE.
//  - FSM: IDLE -> CLEAR -> FEED -> DRAIN -> UNLOAD -> DONE -> IDLE.
//  - IDLE: in_ready=0; start=1 -> CLEAR. start in any other state is ignored, never queued.
//  - CLEAR: exactly 1 cycle, clear=9'h1FF; load=0.
//  - FEED: in_ready=1. Accept = in_valid & in_ready at a rising edge. On accept, data_w/x latch in_w/in_x; load=9'h1FF exactly the next cycle.
//    No accept -> load=0, data_w/x hold (bubble; no counter change). After K_STEPS accepts -> DRAIN, in_ready drops the same edge.
//  - DRAIN: MAC_LAT+1 cycles (first covers final load strobe), load=0 after that strobe.
//  - UNLOAD: 9 cycles, unload_res=1, res_valid=1, res_idx=0,1,..,8; then DONE.
//  - DONE: 1 cycle, done=1, busy=0; then IDLE. A new start is accepted from the following IDLE cycle.
//  - load and clear never both nonzero in one cycle; clear only in CLEAR.
//  - Arithmetic owned by MACs: result = sum over k of W[i][k]*X[k][j]; 10-bit safe for K_STEPS=3, W_BITS=4 (max 675). Sequencer does no wrap checking.
//  - Beat counter: ceil(log2(K_STEPS+1)) bits, compares == K_STEPS, never wraps. Index counter stops at 8.
//  - Zero-bubble timing, MAC_LAT=1, K=3: clear c1; accepts c2..c4; load c3..c5; DRAIN c5..c6; UNLOAD c7..c15; done c16.
// CONFIGURATION
//  MATMUL_SEQ_ACCUM_EN defined: extra input accum (1 bit), sampled with start. accum=1 -> CLEAR skipped (IDLE->FEED, clear stays 0), new products add to existing MAC contents. accum=0 behaves as base.
//  Not defined: port absent, CLEAR always executed.
// TESTING
//  1. rst pulse, then idle 5 cycles -> every output 0, in_ready=0, busy=0.
//  2. W=I, X=[1..9], in_valid held 1, MAC_LAT=1 -> timing exactly as zero-bubble line; res_idx 0..8 reads 1..9.
//  3. All elements 15 -> all nine results 675 (10'h2A3); no overflow.
//  4. in_valid low 2 cycles between beats 1 and 2 -> load has gap of 2, data_w/x held, done at c18, results unchanged.
//  5. rst asserted in c4 (mid-FEED) -> outputs 0 same cycle (async); next start gives clean job, correct results.
//  6. MATMUL_SEQ_ACCUM_EN: job W=I,X=[1..9], then accum=1 repeat -> no clear pulse, second unload reads 2,4,..,18; start during busy ignored.

Source files
------------

// File: rtl/matmul_sequencer.sv
// Job sequencer for the 3x3 MAC-array matrix multiplier: clear, operand feed, drain, result unload.
// Optional build macro MATMUL_SEQ_ACCUM_EN adds the accum input (skip CLEAR, accumulate onto MAC contents).
module matmul_sequencer #(
    parameter int unsigned W_BITS  = 4,
    parameter int unsigned K_STEPS = 3,
    parameter int unsigned MAC_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
`ifdef MATMUL_SEQ_ACCUM_EN
    input  logic                  accum,
`endif
    output logic                  busy,
    output logic                  done,
    input  logic [3*W_BITS-1:0]   in_w,
    input  logic [3*W_BITS-1:0]   in_x,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [W_BITS-1:0]     data_w1,
    output logic [W_BITS-1:0]     data_w2,
    output logic [W_BITS-1:0]     data_w3,
    output logic [W_BITS-1:0]     data_x1,
    output logic [W_BITS-1:0]     data_x2,
    output logic [W_BITS-1:0]     data_x3,
    output logic [8:0]            load,
    output logic [8:0]            clear,
    output logic                  unload_res,
    output logic [3:0]            res_idx,
    output logic                  res_valid
);

    localparam int unsigned BW = $clog2(K_STEPS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_UNLOAD,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [BW-1:0]            beat_q, beat_d, beat_inc;
    logic [2:0]               drain_q, drain_d;
    logic [3:0]               idx_q, idx_d;
    logic [2:0][W_BITS-1:0]   dw_q, dw_d, dx_q, dx_d;
    logic [8:0]               load_q, load_d, clear_q, clear_d;
    logic                     in_ready_q, in_ready_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     unload_q, unload_d;
    logic                     accept;
    logic                     skip_clear;

`ifdef MATMUL_SEQ_ACCUM_EN
    assign skip_clear = accum;
`else
    assign skip_clear = 1'b0;
`endif

    // in_ready_q is high exactly while state_q is FEED, so it gates the handshake directly
    assign accept   = in_valid & in_ready_q;
    assign beat_inc = beat_q + 1'b1;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        drain_d = drain_q;
        idx_d   = '0;
        dw_d    = dw_q;
        dx_d    = dx_q;
        load_d  = '0;
        case (state_q)
            S_IDLE: begin
                beat_d = '0;
                if (start) begin
                    state_d = skip_clear ? S_FEED : S_CLEAR;
                end
            end
            S_CLEAR: state_d = S_FEED;
            S_FEED: begin
                if (accept) begin
                    dw_d   = in_w;
                    dx_d   = in_x;
                    load_d = '1;
                    beat_d = beat_inc;
                    if (beat_inc == BW'(K_STEPS)) begin
                        state_d = S_DRAIN;
                        beat_d  = '0;
                        drain_d = '0;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == 3'(MAC_LAT)) begin
                    state_d = S_UNLOAD;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            S_UNLOAD: begin
                if (idx_q == 4'd8) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered images of the state being entered
        clear_d    = (state_d == S_CLEAR) ? '1 : '0;
        in_ready_d = (state_d == S_FEED);
        busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        unload_d   = (state_d == S_UNLOAD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            beat_q     <= '0;
            drain_q    <= '0;
            idx_q      <= '0;
            dw_q       <= '0;
            dx_q       <= '0;
            load_q     <= '0;
            clear_q    <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            unload_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            drain_q    <= drain_d;
            idx_q      <= idx_d;
            dw_q       <= dw_d;
            dx_q       <= dx_d;
            load_q     <= load_d;
            clear_q    <= clear_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            unload_q   <= unload_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign in_ready   = in_ready_q;
    assign data_w1    = dw_q[0];
    assign data_w2    = dw_q[1];
    assign data_w3    = dw_q[2];
    assign data_x1    = dx_q[0];
    assign data_x2    = dx_q[1];
    assign data_x3    = dx_q[2];
    assign load       = load_q;
    assign clear      = clear_q;
    assign unload_res = unload_q;
    assign res_idx    = idx_q;
    assign res_valid  = unload_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: a stand-in MAC array fed by the DUT, checked against plain matrix products.
// Exercises the accum path when built with MATMUL_SEQ_ACCUM_EN.
module tb_matmul_sequencer;

    localparam int unsigned W_BITS  = 4;
    localparam int unsigned K_STEPS = 3;
    localparam int unsigned MAC_LAT = 1;
    localparam int          MAXV    = (1 << W_BITS) - 1;
`ifdef MATMUL_SEQ_ACCUM_EN
    localparam bit HAS_ACCUM = 1'b1;
`else
    localparam bit HAS_ACCUM = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
`ifdef MATMUL_SEQ_ACCUM_EN
    logic                accum = 1'b0;
`endif
    logic                busy, done, in_ready, unload_res, res_valid;
    logic [3*W_BITS-1:0] in_w = '0, in_x = '0;
    logic                in_valid = 1'b0;
    logic [W_BITS-1:0]   data_w1, data_w2, data_w3, data_x1, data_x2, data_x3;
    logic [8:0]          load, clear;
    logic [3:0]          res_idx;

    int n_cmp = 0;
    int n_err = 0;
    int wm [3][K_STEPS];
    int xm [K_STEPS][3];
    int ref_acc [9];
    int mac_acc [9];

    always #5 clk = ~clk;

    matmul_sequencer #(
        .W_BITS (W_BITS),
        .K_STEPS(K_STEPS),
        .MAC_LAT(MAC_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef MATMUL_SEQ_ACCUM_EN
        .accum     (accum),
`endif
        .busy      (busy),
        .done      (done),
        .in_w      (in_w),
        .in_x      (in_x),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_w1   (data_w1),
        .data_w2   (data_w2),
        .data_w3   (data_w3),
        .data_x1   (data_x1),
        .data_x2   (data_x2),
        .data_x3   (data_x3),
        .load      (load),
        .clear     (clear),
        .unload_res(unload_res),
        .res_idx   (res_idx),
        .res_valid (res_valid)
    );

    logic [50:0] all_out;
    assign all_out = {data_w3, data_w2, data_w1, data_x3, data_x2, data_x1, load, clear,
                      in_ready, busy, done, unload_res, res_valid, res_idx};

    // Stand-in MAC array: product visible the cycle after its load strobe
    logic [W_BITS-1:0] dwv [3];
    logic [W_BITS-1:0] dxv [3];
    assign dwv[0] = data_w1;
    assign dwv[1] = data_w2;
    assign dwv[2] = data_w3;
    assign dxv[0] = data_x1;
    assign dxv[1] = data_x2;
    assign dxv[2] = data_x3;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (clear[3*i+j]) mac_acc[3*i+j] <= 0;
                else if (load[3*i+j]) mac_acc[3*i+j] <= mac_acc[3*i+j] + int'(dwv[i]) * int'(dxv[j]);
            end
        end
    end

    task automatic set_identity_seq();
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < int'(K_STEPS); k++) wm[i][k] = (i == k) ? 1 : 0;
        for (int k = 0; k < int'(K_STEPS); k++)
            for (int j = 0; j < 3; j++) xm[k][j] = 3 * k + j + 1;
    endtask

    task automatic set_const(input int v);
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < int'(K_STEPS); k++) begin
                wm[i][k] = v;
                xm[k][i] = v;
            end
    endtask

    task automatic set_random();
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < int'(K_STEPS); k++) begin
                wm[i][k] = int'($urandom_range(0, MAXV));
                xm[k][i] = int'($urandom_range(0, MAXV));
            end
    endtask

    // One job from the cycle the start is presented; expectations follow from the beat plan alone.
    task automatic run_job(input bit acc_mode, input int gap, input bit poke_start, input int post);
        int a [K_STEPS];
        int fs, a_last, u0, done_c, bk, lb, s, act_res;
        bit skip, is_load;
        logic [26:0] exp_v, act_v;
        logic [3*W_BITS-1:0] exp_dw, exp_dx, act_dw, act_dx;

        skip = HAS_ACCUM && acc_mode;
        fs = skip ? 1 : 2;
        a[0] = fs;
        for (int k = 1; k < int'(K_STEPS); k++) a[k] = a[k-1] + 1 + ((k == 1) ? gap : 0);
        a_last = a[K_STEPS-1];
        u0 = a_last + 2 + int'(MAC_LAT);
        done_c = u0 + 9;

        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                s = skip ? ref_acc[3*i+j] : 0;
                for (int k = 0; k < int'(K_STEPS); k++) s += wm[i][k] * xm[k][j];
                ref_acc[3*i+j] = s;
            end

        start = 1'b1;
`ifdef MATMUL_SEQ_ACCUM_EN
        accum = acc_mode;
`endif
        in_valid = 1'b0;
        for (int c = 1; c <= done_c + post; c++) begin
            @(posedge clk);
            #1;
            start = poke_start && (c == 3 || c == u0 + 2 || c == done_c);
            bk = -1;
            if (c < a[0]) bk = 0;
            for (int k = 0; k < int'(K_STEPS); k++) if (c == a[k]) bk = k;
            in_valid = (bk >= 0) || (c > a_last && c < done_c);
            in_w = 12'($urandom);
            in_x = 12'($urandom);
            if (bk >= 0) begin
                for (int i = 0; i < 3; i++) begin
                    in_w[i*W_BITS +: W_BITS] = W_BITS'(wm[i][bk]);
                    in_x[i*W_BITS +: W_BITS] = W_BITS'(xm[bk][i]);
                end
            end
            @(negedge clk);

            is_load = 1'b0;
            lb = -1;
            for (int k = 0; k < int'(K_STEPS); k++) begin
                if (a[k] + 1 == c) is_load = 1'b1;
                if (a[k] + 1 <= c) lb = k;
            end
            exp_v = {((!skip && c == 1) ? 9'h1FF : 9'h000),
                     (is_load ? 9'h1FF : 9'h000),
                     (c >= fs && c <= a_last),
                     (c >= 1 && c < done_c),
                     (c == done_c),
                     (c >= u0 && c < u0 + 9),
                     (c >= u0 && c < u0 + 9),
                     ((c >= u0 && c < u0 + 9) ? 4'(c - u0) : 4'd0)};
            act_v = {clear, load, in_ready, busy, done, unload_res, res_valid, res_idx};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL ctrl c=%0d act=%h exp=%h (clear,load,rdy,busy,done,unl,rv,idx)", c, act_v, exp_v);
            end

            if (lb >= 0 && c <= done_c) begin
                for (int i = 0; i < 3; i++) begin
                    exp_dw[i*W_BITS +: W_BITS] = W_BITS'(wm[i][lb]);
                    exp_dx[i*W_BITS +: W_BITS] = W_BITS'(xm[lb][i]);
                end
                act_dw = {data_w3, data_w2, data_w1};
                act_dx = {data_x3, data_x2, data_x1};
                n_cmp++;
                if (act_dw !== exp_dw || act_dx !== exp_dx) begin
                    n_err++;
                    $display("FAIL operands c=%0d act=%h/%h exp=%h/%h", c, act_dw, act_dx, exp_dw, exp_dx);
                end
            end

            if (c >= u0 && c < u0 + 9) begin
                act_res = (res_idx < 4'd9) ? mac_acc[res_idx] : -1;
                n_cmp++;
                if (act_res != ref_acc[c-u0]) begin
                    n_err++;
                    $display("FAIL result idx=%0d act=%0d exp=%0d", c - u0, act_res, ref_acc[c-u0]);
                end
            end
        end
        start = 1'b0;
        in_valid = 1'b0;
`ifdef MATMUL_SEQ_ACCUM_EN
        accum = 1'b0;
`endif
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (all_out !== '0) begin
            n_err++;
            $display("FAIL reset_async act=%h exp=0", all_out);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (all_out !== '0) begin
                n_err++;
                $display("FAIL reset_idle cyc=%0d act=%h exp=0", i, all_out);
            end
        end
    endtask

    task automatic test_identity();
        set_identity_seq();
        run_job(1'b0, 0, 1'b0, 1);
    endtask

    task automatic test_all_max();
        set_const(MAXV);
        run_job(1'b0, 0, 1'b0, 1);
    endtask

    task automatic test_bubble();
        set_random();
        run_job(1'b0, 2, 1'b0, 1);
    endtask

    task automatic test_reset_mid_job();
        @(negedge clk);
        start = 1'b1;
        in_valid = 1'b1;
        in_w = 12'($urandom);
        in_x = 12'($urandom);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (all_out !== '0) begin
            n_err++;
            $display("FAIL reset_mid act=%h exp=0", all_out);
        end
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (all_out !== '0) begin
            n_err++;
            $display("FAIL reset_mid_idle act=%h exp=0", all_out);
        end
        set_random();
        run_job(1'b0, 0, 1'b0, 1);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 4; n++) begin
            set_random();
            run_job(1'b0, int'($urandom_range(0, 3)), n[0], 1);
        end
    endtask

    task automatic test_accum();
        set_identity_seq();
        run_job(1'b0, 0, 1'b0, 1);
        run_job(1'b1, 0, 1'b1, 2);
        set_random();
        run_job(1'b1, 1, 1'b0, 1);
    endtask

    initial begin
        test_reset();
        test_identity();
        test_all_max();
        test_bubble();
        test_reset_mid_job();
        test_back_to_back();
        if (HAS_ACCUM) test_accum();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
